// File: rtl/viterbi_obs_loader.sv
// Observation-frame loader and ap_ctrl_hs sequencer for the viterbi core.
// Optional tdata clamp to N_TOKENS-1 enabled by defining VITERBI_OBS_RANGE_CHECK_EN.
module viterbi_obs_loader #(
  parameter int N_OBS    = 128,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 32,
  parameter int N_TOKENS = 64
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [DATA_W-1:0] s_obs_tdata,
  input  logic              s_obs_tvalid,
  output logic              s_obs_tready,
  input  logic              s_obs_tlast,
  output logic [ADDR_W-1:0] obs_address0,
  output logic              obs_ce0,
  output logic              obs_we0,
  output logic [DATA_W-1:0] obs_d0,
  output logic              vit_start,
  input  logic              vit_ready,
  input  logic              vit_done,
  input  logic [31:0]       vit_return,
  output logic [31:0]       res_data,
  output logic [2:0]        res_status,
  output logic              res_valid,
  input  logic              res_ready
);

  // Stream handshake: a beat transfers on a rising edge where s_obs_tvalid and
  // s_obs_tready are both 1; the result transfers where res_valid and res_ready are both 1.

  typedef enum logic [2:0] {
    S_LOAD, S_PAD, S_DRAIN, S_START, S_WAIT, S_RESULT
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
  logic [2:0]        status, status_nxt;
  logic              run;
  logic              beat;
  logic              last_addr;
  logic              clamp_hit;
  logic              capture;
  logic [DATA_W-1:0] wr_data;

  if (ADDR_W != $clog2(N_OBS) || N_TOKENS < 1) begin : g_bad_cfg
    $error("viterbi_obs_loader: ADDR_W must equal clog2(N_OBS) and N_TOKENS must be positive");
  end

`ifdef VITERBI_OBS_RANGE_CHECK_EN
  assign clamp_hit = (s_obs_tdata >= DATA_W'(N_TOKENS));
  assign wr_data   = clamp_hit ? DATA_W'(N_TOKENS - 1) : s_obs_tdata;
`else
  assign clamp_hit = 1'b0;
  assign wr_data   = s_obs_tdata;
`endif

  // run holds the stream closed until the first edge after reset release.
  assign last_addr    = (wr_ptr == ADDR_W'(N_OBS - 1));
  assign s_obs_tready = run && (state == S_LOAD || state == S_DRAIN);
  assign beat         = s_obs_tvalid && s_obs_tready;
  assign capture      = (state == S_START && vit_ready && vit_done) ||
                        (state == S_WAIT && vit_done);

  always_comb begin
    obs_address0 = wr_ptr;
    obs_ce0      = 1'b0;
    obs_we0      = 1'b0;
    obs_d0       = '0;
    if (state == S_LOAD && beat) begin
      obs_ce0 = 1'b1;
      obs_we0 = 1'b1;
      obs_d0  = wr_data;
    end else if (state == S_PAD && run) begin
      obs_ce0 = 1'b1;
      obs_we0 = 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    status_nxt = status;
    case (state)
      S_LOAD: begin
        if (beat) begin
          wr_ptr_nxt = wr_ptr + 1'b1;
          if (clamp_hit) status_nxt[2] = 1'b1;
          if (s_obs_tlast) begin
            if (last_addr) begin
              state_nxt = S_START;
            end else begin
              status_nxt[0] = 1'b1;
              state_nxt     = S_PAD;
            end
          end else if (last_addr) begin
            status_nxt[1] = 1'b1;
            state_nxt     = S_DRAIN;
          end
        end
      end
      S_PAD: begin
        wr_ptr_nxt = wr_ptr + 1'b1;
        if (last_addr) state_nxt = S_START;
      end
      S_DRAIN: begin
        if (beat && s_obs_tlast) state_nxt = S_START;
      end
      S_START: begin
        wr_ptr_nxt = '0;
        if (vit_ready) state_nxt = vit_done ? S_RESULT : S_WAIT;
      end
      S_WAIT: begin
        if (vit_done) state_nxt = S_RESULT;
      end
      S_RESULT: begin
        if (res_valid && res_ready) begin
          status_nxt = '0;
          state_nxt  = S_LOAD;
        end
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state      <= S_LOAD;
      wr_ptr     <= '0;
      status     <= '0;
      run        <= 1'b0;
      vit_start  <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_status <= '0;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_ptr_nxt;
      status    <= status_nxt;
      run       <= 1'b1;
      vit_start <= (state_nxt == S_START);
      res_valid <= (state_nxt == S_RESULT);
      if (capture) begin
        res_data <= vit_return;
`ifdef VITERBI_OBS_RANGE_CHECK_EN
        res_status <= status;
`else
        res_status <= {1'b0, status[1:0]};
`endif
      end
    end
  end

endmodule
